// File: rtl/sync_down_counter.sv
// Synchronous loadable down counter with terminal-count pulse and optional auto-reload.
// Define WRAP_CNT_EN to add the saturating WRAPS auto-reload event counter output.
module sync_down_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             EN,
    input  logic             AUTO_RELOAD,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             BUSY,
    output logic             DONE
`ifdef WRAP_CNT_EN
    ,
    output logic [7:0]       WRAPS
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (LOAD) begin
            count_d  = LOAD_VAL;
            reload_d = LOAD_VAL;
            state_d  = (LOAD_VAL != '0) ? StRun : StDone;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (EN) begin
                        count_d = count_q - One;
                        tc_d    = (count_q == One);
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (EN) begin
                        if (count_q > One) begin
                            count_d = count_q - One;
                        end else if (count_q == One) begin
                            count_d = '0;
                            tc_d    = 1'b1;
                        end else if (AUTO_RELOAD) begin
                            count_d = reload_q;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            count_q  <= '1;
            reload_q <= '1;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

`ifdef WRAP_CNT_EN
    logic [7:0] wraps_q, wraps_d;
    logic       wrap_evt;

    always_comb begin
        wrap_evt = !LOAD && (state_q == StRun) && EN && (count_q == '0) && AUTO_RELOAD;
        wraps_d  = wraps_q;
        if (LOAD) begin
            wraps_d = '0;
        end else if (wrap_evt && (wraps_q != 8'hFF)) begin
            wraps_d = wraps_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wraps_q <= '0;
        end else begin
            wraps_q <= wraps_d;
        end
    end

    assign WRAPS = wraps_q;
`endif

    assign Q    = count_q;
    assign TC   = tc_q;
    assign BUSY = (state_q == StRun);
    assign DONE = (state_q == StDone);

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed self-checking bench for sync_down_counter (WIDTH=3).
module tb_sync_down_counter;

    logic       clk = 1'b0;
    logic       rst, load, en, auto_reload;
    logic [2:0] load_val;
    logic [2:0] q;
    logic       tc, busy, done;
`ifdef WRAP_CNT_EN
    logic [7:0] wraps;
`endif

    int checks = 0;
    int errors = 0;

    sync_down_counter #(.WIDTH(3)) dut (
        .CLK         (clk),
        .RST         (rst),
        .LOAD        (load),
        .LOAD_VAL    (load_val),
        .EN          (en),
        .AUTO_RELOAD (auto_reload),
        .Q           (q),
        .TC          (tc),
        .BUSY        (busy),
        .DONE        (done)
`ifdef WRAP_CNT_EN
        ,
        .WRAPS       (wraps)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; en = 1'b0; auto_reload = 1'b0; load_val = 3'd0;
        tick();
        checks++;
        if (q !== 3'd7 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: q=%0d tc=%b busy=%b done=%b, want q=7 tc=0 busy=0 done=0",
                     q, tc, busy, done);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (q !== 3'd7 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: q=%0d busy=%b, want q=7 busy=0", q, busy);
        end
    endtask

    task automatic test_count_to_done();
        en = 1'b1; auto_reload = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q !== 3'(7 - i) || tc !== (i == 7)) begin
                errors++;
                $display("FAIL count_down[%0d]: q=%0d tc=%b, want q=%0d tc=%b",
                         i, q, tc, 7 - i, (i == 7));
            end
            if (i < 7) tick();
        end
        tick();
        checks++;
        if (q !== 3'd0 || done !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL enter_done: q=%0d done=%b busy=%b tc=%b, want 0 1 0 0",
                     q, done, busy, tc);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (q !== 3'd0 || done !== 1'b1 || tc !== 1'b0) begin
                errors++;
                $display("FAIL done_hold[%0d]: q=%0d done=%b tc=%b, want 0 1 0",
                         i, q, done, tc);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_auto_reload();
        logic [2:0] exp_q [10];
        logic       exp_tc [10];
        exp_q  = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd3, 3'd2, 3'd1, 3'd0, 3'd3, 3'd2};
        exp_tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        load = 1'b1; load_val = 3'd3; en = 1'b0;
        tick();
        load = 1'b0; auto_reload = 1'b1; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (q !== exp_q[i] || tc !== exp_tc[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL auto_reload[%0d]: q=%0d tc=%b busy=%b, want q=%0d tc=%b busy=1",
                         i, q, tc, busy, exp_q[i], exp_tc[i]);
            end
            if (i < 9) tick();
        end
`ifdef WRAP_CNT_EN
        checks++;
        if (wraps !== 8'd2) begin
            errors++;
            $display("FAIL wraps_count: wraps=%0d, want 2", wraps);
        end
`endif
        en = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_val = 3'd2; en = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (q !== 3'd2) begin
            errors++;
            $display("FAIL load_two: q=%0d, want 2", q);
        end
        load = 1'b1; load_val = 3'd5; en = 1'b1;
        tick();
        load = 1'b0; en = 1'b0;
        checks++;
        if (q !== 3'd5 || busy !== 1'b1 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load_over_en: q=%0d busy=%b tc=%b, want q=5 busy=1 tc=0",
                     q, busy, tc);
        end
`ifdef WRAP_CNT_EN
        checks++;
        if (wraps !== 8'd0) begin
            errors++;
            $display("FAIL wraps_clear: wraps=%0d, want 0", wraps);
        end
`endif
    endtask

    task automatic test_load_zero();
        logic [2:0] exp_q [5];
        logic       exp_tc [5];
        exp_q  = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
        exp_tc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        load = 1'b1; load_val = 3'd0; en = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (q !== 3'd0 || done !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load_zero: q=%0d done=%b busy=%b tc=%b, want 0 1 0 0",
                     q, done, busy, tc);
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (q !== 3'd0 || done !== 1'b1 || tc !== 1'b0) begin
                errors++;
                $display("FAIL zero_ignore_en[%0d]: q=%0d done=%b tc=%b, want 0 1 0",
                         i, q, done, tc);
            end
        end
        load = 1'b1; load_val = 3'd1; auto_reload = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (q !== exp_q[i] || tc !== exp_tc[i]) begin
                errors++;
                $display("FAIL reload_one[%0d]: q=%0d tc=%b, want q=%0d tc=%b",
                         i, q, tc, exp_q[i], exp_tc[i]);
            end
            if (i < 4) tick();
        end
        en = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        load = 1'b1; load_val = 3'd4; en = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (q !== 3'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_four: q=%0d busy=%b, want q=4 busy=1", q, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (q !== 3'd7 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: q=%0d tc=%b busy=%b done=%b, want 7 0 0 0",
                     q, tc, busy, done);
        end
        tick();
        tick();
        checks++;
        if (q !== 3'd7 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hold: q=%0d busy=%b, want q=7 busy=0", q, busy);
        end
        // Reset must win over a pending 1->0 step and suppress its TC.
        load = 1'b1; load_val = 3'd1;
        tick();
        load = 1'b0; en = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        checks++;
        if (q !== 3'd7 || tc !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_tc: q=%0d tc=%b busy=%b, want 7 0 0", q, tc, busy);
        end
    endtask

    task automatic test_en_toggle();
        logic       pat [4];
        logic [2:0] exp_q [4];
        logic       exp_tc [4];
        pat    = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_q  = '{3'd1, 3'd1, 3'd0, 3'd0};
        exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0};
        load = 1'b1; load_val = 3'd2; en = 1'b0; auto_reload = 1'b0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en = pat[i];
            tick();
            checks++;
            if (q !== exp_q[i] || tc !== exp_tc[i]) begin
                errors++;
                $display("FAIL en_toggle[%0d]: q=%0d tc=%b, want q=%0d tc=%b",
                         i, q, tc, exp_q[i], exp_tc[i]);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_to_done();
        test_auto_reload();
        test_load_priority();
        test_load_zero();
        test_reset_mid_count();
        test_en_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
